// File: rtl/ahb_slave_mem_pkg.sv
// Shared definitions for the AHB-Lite slave memory front-end.
//   - HTRANS / HRESP encodings
//   - FSM state and transfer-class enums
//   - bytes-per-beat log2 helper used for address matching and size checks
package ahb_slave_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2,
        StTmo
    } state_e;

    typedef enum logic [1:0] {
        ClsNormal,
        ClsErr,
        ClsTmo
    } cls_e;

    // log2 of the number of bytes carried by one bus beat
    function automatic int unsigned bpb_log2(input int unsigned data_bits);
        return $clog2(data_bits / 8);
    endfunction

endpackage

// File: rtl/ahb_slave_mem_bsel.sv
// Byte-enable decode for the memory write port.
//   hsize   : registered transfer size (bytes = 2^hsize)
//   addr_lo : registered address bits below the beat boundary
//   en      : write strobe; bsel is zero when low
//   bsel    : one bit per byte lane of the data bus
module ahb_slave_mem_bsel
    import ahb_slave_pkg::*;
#(
    parameter int unsigned DATA_BITS = 32,
    localparam int unsigned Bytes    = DATA_BITS / 8,
    localparam int unsigned Lsb      = bpb_log2(DATA_BITS)
) (
    input  logic [2:0]       hsize,
    input  logic [Lsb-1:0]   addr_lo,
    input  logic             en,
    output logic [Bytes-1:0] bsel
);

    logic [31:0]      nbytes;
    logic [31:0]      offset;
    logic [Bytes-1:0] ones;

    always_comb begin
        nbytes = 32'd1 << hsize;
        // Unaligned addresses are rounded down to the transfer size.
        offset = 32'(addr_lo) & ~(nbytes - 32'd1);
        ones   = '0;
        for (int unsigned i = 0; i < Bytes; i++) begin
            ones[i] = (i < nbytes);
        end
        bsel = en ? (ones << offset) : '0;
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave front-end for a single-port synchronous memory.
//   clk, reset             : clock, asynchronous active-low reset
//   HADDR..HWDATA          : AHB-Lite address/data phase inputs
//   HRDATA, HREADY, HRESP  : AHB-Lite response
//   wait_cfg               : extra data-phase wait cycles, sampled at acceptance
//   err_en/err_addr        : beat address answered with a two-cycle ERROR
//   tmo_en/tmo_addr        : beat address stalled for as long as tmo_en is high
//   RD/ADDR_RD             : memory read strobe/address (combinational, address phase)
//   WR/ADDR_WR/BSEL/DIN    : memory write strobe/address/byte enables/data (data phase)
//   DOUT                   : memory read data, valid RD_LAT cycles after RD
module ahb_slave_mem
    import ahb_slave_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 24,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned WAIT_BITS = 4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_BITS-1:0]   HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [DATA_BITS-1:0]   HWDATA,
    output logic [DATA_BITS-1:0]   HRDATA,
    output logic                   HREADY,
    output logic                   HRESP,
    input  logic [WAIT_BITS-1:0]   wait_cfg,
    input  logic                   err_en,
    input  logic [ADDR_BITS-1:0]   err_addr,
    input  logic                   tmo_en,
    input  logic [ADDR_BITS-1:0]   tmo_addr,
    output logic                   RD,
    output logic [ADDR_BITS-1:0]   ADDR_RD,
    output logic                   WR,
    output logic [ADDR_BITS-1:0]   ADDR_WR,
    output logic [DATA_BITS/8-1:0] BSEL,
    output logic [DATA_BITS-1:0]   DIN,
    input  logic [DATA_BITS-1:0]   DOUT
);

    localparam int unsigned          Lsb       = bpb_log2(DATA_BITS);
    localparam logic [2:0]           MaxSize   = 3'(Lsb);
    localparam logic [WAIT_BITS-1:0] RdMinWait = WAIT_BITS'(RD_LAT - 1);
    localparam logic [WAIT_BITS-1:0] CntOne    = WAIT_BITS'(1);

    state_e                 state_q, state_d, first_state;
    cls_e                   cls_q, cls_in;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   write_q;
    logic [2:0]             size_q;
    logic [WAIT_BITS-1:0]   cnt_q, cnt_d, wait_n;
    logic                   hready_q, hresp_q;
    logic [RD_LAT-1:0]      rd_sr_q;
    logic                   dout_valid;
    logic [DATA_BITS-1:0]   hold_q;
    logic                   accept;
    logic                   tmo_match, err_match;
    logic                   data_read;
    logic                   unused_addr_lo;

    assign unused_addr_lo = ^{err_addr[Lsb-1:0], tmo_addr[Lsb-1:0]};

    assign accept    = hready_q & ((HTRANS == HtransNonseq) | (HTRANS == HtransSeq));
    assign tmo_match = (HADDR[ADDR_BITS-1:Lsb] == tmo_addr[ADDR_BITS-1:Lsb]);
    assign err_match = (HADDR[ADDR_BITS-1:Lsb] == err_addr[ADDR_BITS-1:Lsb]);

    always_comb begin
        cls_in = ClsNormal;
        if (tmo_en && tmo_match) begin
            cls_in = ClsTmo;
        end else if ((err_en && err_match) || (HSIZE > MaxSize)) begin
            cls_in = ClsErr;
        end
    end

    // Reads never complete before the memory can deliver data.
    always_comb begin
        wait_n = wait_cfg;
        if (!HWRITE && (wait_cfg < RdMinWait)) begin
            wait_n = RdMinWait;
        end
    end

    always_comb begin
        case (cls_in)
            ClsTmo:  first_state = StTmo;
            ClsErr:  first_state = StErr1;
            default: first_state = (wait_n == '0) ? StData : StWait;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StData, StErr2: state_d = accept ? first_state : StIdle;
            StWait: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q <= CntOne) begin
                    state_d = StData;
                end
            end
            StErr1: state_d = StErr2;
            StTmo: begin
                if (!tmo_en) begin
                    state_d = StData;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            cnt_d = wait_n;
        end
    end

    // Handshake outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hready_q <= 1'b1;
            hresp_q  <= HrespOkay;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hready_q <= (state_d == StIdle) || (state_d == StData) || (state_d == StErr2);
            hresp_q  <= ((state_d == StErr1) || (state_d == StErr2)) ? HrespError : HrespOkay;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            cls_q   <= ClsNormal;
        end else if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            cls_q   <= cls_in;
        end
    end

    // Tracks which cycle DOUT answers an earlier RD.
    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_sr_q <= '0;
            end else begin
                rd_sr_q <= RD;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_sr_q <= '0;
            end else begin
                rd_sr_q <= {rd_sr_q[RD_LAT-2:0], RD};
            end
        end
    end

    assign dout_valid = rd_sr_q[RD_LAT-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (dout_valid) begin
            hold_q <= DOUT;
        end
    end

    assign RD      = reset & accept & (cls_in == ClsNormal) & ~HWRITE;
    assign ADDR_RD = RD ? HADDR : '0;

    assign data_read = (state_q == StData) && (cls_q == ClsNormal) && !write_q;
    assign HRDATA    = data_read ? (dout_valid ? DOUT : hold_q) : '0;

    assign WR      = reset & (state_q == StData) & (cls_q == ClsNormal) & write_q;
    assign ADDR_WR = WR ? addr_q : '0;
    assign DIN     = HWDATA;

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;

    ahb_slave_mem_bsel #(
        .DATA_BITS(DATA_BITS)
    ) u_bsel (
        .hsize  (size_q),
        .addr_lo(addr_q[Lsb-1:0]),
        .en     (WR),
        .bsel   (BSEL)
    );

endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;

    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TB = 2'b01;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;
    localparam logic [31:0] JunkA = 32'hDEAD_BEEF;
    localparam logic [63:0] JunkB = 64'hDEAD_BEEF_CAFE_F00D;

    logic clk;
    logic rst_a, rst_b;

    // DUT A: 32-bit bus, RD_LAT=1
    logic [23:0] haddr_a, err_addr_a, tmo_addr_a, addr_rd_a, addr_wr_a;
    logic [1:0]  htrans_a;
    logic        hwrite_a, hready_a, hresp_a, err_en_a, tmo_en_a, rd_a, wr_a;
    logic [2:0]  hsize_a;
    logic [31:0] hwdata_a, hrdata_a, din_a, dout_a;
    logic [3:0]  wcfg_a, bsel_a;

    // DUT B: 64-bit bus, RD_LAT=2
    logic [23:0] haddr_b, err_addr_b, tmo_addr_b, addr_rd_b, addr_wr_b;
    logic [1:0]  htrans_b;
    logic        hwrite_b, hready_b, hresp_b, err_en_b, tmo_en_b, rd_b, wr_b;
    logic [2:0]  hsize_b;
    logic [63:0] hwdata_b, hrdata_b, din_b, dout_b;
    logic [3:0]  wcfg_b;
    logic [7:0]  bsel_b;

    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ahb_slave_mem #(.ADDR_BITS(24), .DATA_BITS(32), .WAIT_BITS(4), .RD_LAT(1)) u_dut_a (
        .clk(clk), .reset(rst_a), .HADDR(haddr_a), .HTRANS(htrans_a), .HWRITE(hwrite_a),
        .HSIZE(hsize_a), .HWDATA(hwdata_a), .HRDATA(hrdata_a), .HREADY(hready_a),
        .HRESP(hresp_a), .wait_cfg(wcfg_a), .err_en(err_en_a), .err_addr(err_addr_a),
        .tmo_en(tmo_en_a), .tmo_addr(tmo_addr_a), .RD(rd_a), .ADDR_RD(addr_rd_a),
        .WR(wr_a), .ADDR_WR(addr_wr_a), .BSEL(bsel_a), .DIN(din_a), .DOUT(dout_a)
    );

    ahb_slave_mem #(.ADDR_BITS(24), .DATA_BITS(64), .WAIT_BITS(4), .RD_LAT(2)) u_dut_b (
        .clk(clk), .reset(rst_b), .HADDR(haddr_b), .HTRANS(htrans_b), .HWRITE(hwrite_b),
        .HSIZE(hsize_b), .HWDATA(hwdata_b), .HRDATA(hrdata_b), .HREADY(hready_b),
        .HRESP(hresp_b), .wait_cfg(wcfg_b), .err_en(err_en_b), .err_addr(err_addr_b),
        .tmo_en(tmo_en_b), .tmo_addr(tmo_addr_b), .RD(rd_b), .ADDR_RD(addr_rd_b),
        .WR(wr_b), .ADDR_WR(addr_wr_b), .BSEL(bsel_b), .DIN(din_b), .DOUT(dout_b)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Memory models: write-first on same-address RD/WR in one cycle.
    logic [31:0] mem_a [0:255];
    logic [31:0] wr_word_a, rd_word_a;
    always_comb begin
        wr_word_a = 32'(merge({32'h0, mem_a[addr_wr_a[9:2]]}, {32'h0, din_a}, {4'h0, bsel_a}));
        rd_word_a = (wr_a && addr_wr_a[9:2] == addr_rd_a[9:2]) ? wr_word_a
                                                               : mem_a[addr_rd_a[9:2]];
    end
    always @(posedge clk) begin
        if (!rst_a) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'h0;
        end else if (wr_a) begin
            mem_a[addr_wr_a[9:2]] <= wr_word_a;
        end
        dout_a <= rd_a ? rd_word_a : JunkA;
    end

    logic [63:0] mem_b [0:15];
    logic [63:0] wr_word_b, rd_word_b, s1_d_b;
    logic        s1_v_b;
    always_comb begin
        wr_word_b = merge(mem_b[addr_wr_b[6:3]], din_b, bsel_b);
        rd_word_b = (wr_b && addr_wr_b[6:3] == addr_rd_b[6:3]) ? wr_word_b
                                                               : mem_b[addr_rd_b[6:3]];
    end
    always @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= 64'h0;
        end else if (wr_b) begin
            mem_b[addr_wr_b[6:3]] <= wr_word_b;
        end
        s1_v_b <= rd_b;
        s1_d_b <= rd_word_b;
        dout_b <= s1_v_b ? s1_d_b : JunkB;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wcfg;
        logic        rdy;
        logic        resp;
        logic        rd;
        logic        wr;
        logic [3:0]  bsel;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] t, input logic w, input logic [2:0] s,
                                input logic [23:0] a, input logic [31:0] wd,
                                input logic [3:0] wc, input logic rdy, input logic resp,
                                input logic rd, input logic wr, input logic [3:0] be,
                                input logic [31:0] rdata);
        vec_t v;
        v.trans = t; v.write = w; v.size = s; v.addr = a; v.wdata = wd; v.wcfg = wc;
        v.rdy = rdy; v.resp = resp; v.rd = rd; v.wr = wr; v.bsel = be; v.rdata = rdata;
        return v;
    endfunction

    task automatic cyc_b(input string nm, input logic [1:0] t, input logic w,
                         input logic [2:0] s, input logic [23:0] a, input logic [63:0] wd,
                         input logic [3:0] wc, input logic e_rdy, input logic e_resp,
                         input logic e_rd, input logic e_wr, input logic [7:0] e_bsel,
                         input logic [63:0] e_rdata);
        htrans_b = t; hwrite_b = w; hsize_b = s; haddr_b = a; hwdata_b = wd; wcfg_b = wc;
        @(negedge clk);
        check({nm, " hready"}, {63'h0, hready_b}, {63'h0, e_rdy});
        check({nm, " hresp"}, {63'h0, hresp_b}, {63'h0, e_resp});
        check({nm, " rd"}, {63'h0, rd_b}, {63'h0, e_rd});
        check({nm, " addr_rd"}, {40'h0, addr_rd_b}, e_rd ? {40'h0, a} : 64'h0);
        check({nm, " wr"}, {63'h0, wr_b}, {63'h0, e_wr});
        check({nm, " bsel"}, {56'h0, bsel_b}, {56'h0, e_bsel});
        check({nm, " hrdata"}, hrdata_b, e_rdata);
        @(posedge clk); #1;
    endtask

    vec_t va[$];
    int   beat, first_cyc, last_cyc, wr_cnt, low_cnt, wr_seen;
    logic acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        htrans_a = TN; hwrite_a = 1'b0; hsize_a = 3'd2; haddr_a = 24'h100; hwdata_a = '0;
        wcfg_a = '0; err_en_a = 1'b1; err_addr_a = 24'h40; tmo_en_a = 1'b0;
        tmo_addr_a = 24'h80;
        htrans_b = TN; hwrite_b = 1'b0; hsize_b = 3'd3; haddr_b = 24'h0; hwdata_b = '0;
        wcfg_b = '0; err_en_b = 1'b0; err_addr_b = 24'h0; tmo_en_b = 1'b0;
        tmo_addr_b = 24'hFFFF00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        // NONSEQ read is being driven: RD must still be held low in reset.
        check("rst_a hready", {63'h0, hready_a}, 64'h1);
        check("rst_a hresp", {63'h0, hresp_a}, 64'h0);
        check("rst_a hrdata", {32'h0, hrdata_a}, 64'h0);
        check("rst_a rd", {63'h0, rd_a}, 64'h0);
        check("rst_a wr", {63'h0, wr_a}, 64'h0);
        check("rst_a bsel", {60'h0, bsel_a}, 64'h0);
        check("rst_a addr_rd", {40'h0, addr_rd_a}, 64'h0);
        check("rst_a addr_wr", {40'h0, addr_wr_a}, 64'h0);
        check("rst_b hready", {63'h0, hready_b}, 64'h1);
        check("rst_b rd", {63'h0, rd_b}, 64'h0);
        check("rst_b hrdata", hrdata_b, 64'h0);
        @(posedge clk); #1;
        htrans_a = TI; htrans_b = TI;
        rst_a = 1'b1; rst_b = 1'b1;

        //          trans wr sz  addr     wdata         wc  rdy rsp rd wr bsel rdata
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 1, 2, 24'h100, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 0, 2, 24'h100, 32'hA5A5A5A5, 0, 1, 0, 1, 1, 4'hF, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'hA5A5A5A5));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 1, 0, 24'h201, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 1, 1, 24'h202, 32'h00001100, 0, 1, 0, 0, 1, 4'h2, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'hBEEF0000, 0, 1, 0, 0, 1, 4'hC, 32'h0));
        va.push_back(mk(TN, 0, 2, 24'h200, 32'h0,        0, 1, 0, 1, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'hBEEF1100));
        va.push_back(mk(TB, 0, 2, 24'h300, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 1, 2, 24'h104, 32'h0,        3, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h12345678, 0, 0, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h12345678, 0, 0, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h12345678, 0, 0, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h12345678, 0, 1, 0, 0, 1, 4'hF, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 0, 2, 24'h040, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 0, 1, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 1, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 1, 1, 24'h042, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 0, 1, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 0, 2, 24'h104, 32'h0,        0, 1, 1, 1, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h12345678));
        va.push_back(mk(TN, 1, 3, 24'h108, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 0, 1, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 1, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));
        va.push_back(mk(TN, 0, 2, 24'h100, 32'h0,        0, 1, 0, 1, 0, 4'h0, 32'h0));
        va.push_back(mk(TS, 0, 2, 24'h104, 32'h0,        0, 1, 0, 1, 0, 4'h0, 32'hA5A5A5A5));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h12345678));
        va.push_back(mk(TI, 0, 2, 24'h000, 32'h0,        0, 1, 0, 0, 0, 4'h0, 32'h0));

        for (int i = 0; i < va.size(); i++) begin
            htrans_a = va[i].trans; hwrite_a = va[i].write; hsize_a = va[i].size;
            haddr_a = va[i].addr; hwdata_a = va[i].wdata; wcfg_a = va[i].wcfg;
            @(negedge clk);
            check($sformatf("v%0d hready", i), {63'h0, hready_a}, {63'h0, va[i].rdy});
            check($sformatf("v%0d hresp", i), {63'h0, hresp_a}, {63'h0, va[i].resp});
            check($sformatf("v%0d rd", i), {63'h0, rd_a}, {63'h0, va[i].rd});
            check($sformatf("v%0d wr", i), {63'h0, wr_a}, {63'h0, va[i].wr});
            check($sformatf("v%0d bsel", i), {60'h0, bsel_a}, {60'h0, va[i].bsel});
            check($sformatf("v%0d hrdata", i), {32'h0, hrdata_a}, {32'h0, va[i].rdata});
            @(posedge clk); #1;
        end

        // 4-beat write burst with wait_cfg=3: 4 data-phase cycles per beat.
        wcfg_a = 4'd3; beat = 0; first_cyc = -1; last_cyc = -1; wr_cnt = 0; low_cnt = 0;
        htrans_a = TN; hwrite_a = 1'b1; hsize_a = 3'd2; haddr_a = 24'h110;
        hwdata_a = 32'h0BAD_F00D;
        for (int cyc = 0; cyc < 60 && wr_cnt < 4; cyc++) begin
            @(negedge clk);
            if (!hready_a) low_cnt++;
            if (wr_a) begin
                wr_cnt++;
                last_cyc = cyc;
            end
            acc = hready_a && htrans_a[1];
            @(posedge clk); #1;
            if (acc) begin
                if (beat == 0) first_cyc = cyc;
                beat++;
                if (beat < 4) begin
                    htrans_a = TS;
                    haddr_a = 24'h110 + 24'(4 * beat);
                end else begin
                    htrans_a = TI;
                end
            end
        end
        check("burst wr_count", 64'(wr_cnt), 64'd4);
        check("burst cycles", 64'(last_cyc - first_cyc), 64'd16);
        check("burst wait_cycles", 64'(low_cnt), 64'd12);
        htrans_a = TI; wcfg_a = 4'd0;
        @(posedge clk); #1;

        // Hold-off address: stalls until tmo_en drops, then one OKAY cycle, no WR.
        tmo_en_a = 1'b1;
        htrans_a = TN; hwrite_a = 1'b1; hsize_a = 3'd2; haddr_a = 24'h80;
        @(negedge clk);
        check("tmo accept hready", {63'h0, hready_a}, 64'h1);
        @(posedge clk); #1;
        htrans_a = TI; hwdata_a = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("tmo stall%0d hready", k), {63'h0, hready_a}, 64'h0);
            check($sformatf("tmo stall%0d wr", k), {63'h0, wr_a}, 64'h0);
            @(posedge clk); #1;
        end
        tmo_en_a = 1'b0;
        @(negedge clk);
        check("tmo release hready", {63'h0, hready_a}, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("tmo data hready", {63'h0, hready_a}, 64'h1);
        check("tmo data hresp", {63'h0, hresp_a}, 64'h0);
        check("tmo data wr", {63'h0, wr_a}, 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("tmo after hready", {63'h0, hready_a}, 64'h1);
        @(posedge clk); #1;

        // Reset asserted during a hold-off stall.
        tmo_en_a = 1'b1;
        htrans_a = TN; haddr_a = 24'h80;
        @(posedge clk); #1;
        htrans_a = TI;
        @(negedge clk);
        check("tmo2 stall hready", {63'h0, hready_a}, 64'h0);
        #2;
        rst_a = 1'b0;
        #1;
        check("async rst hready", {63'h0, hready_a}, 64'h1);
        check("async rst hresp", {63'h0, hresp_a}, 64'h0);
        check("async rst wr", {63'h0, wr_a}, 64'h0);
        check("async rst bsel", {60'h0, bsel_a}, 64'h0);
        wr_seen = 0;
        @(posedge clk); #1;
        tmo_en_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wr_a) wr_seen++;
            @(posedge clk); #1;
        end
        check("post rst wr_count", 64'(wr_seen), 64'd0);
        check("post rst hready", {63'h0, hready_a}, 64'h1);

        // DUT B: 64-bit byte lanes, oversize error, RD_LAT=2 read timing.
        cyc_b("b byte acc", TN, 1, 0, 24'h5, 64'h0, 0, 1, 0, 0, 0, 8'h00, 64'h0);
        cyc_b("b half acc", TN, 1, 1, 24'h6, 64'h0000_3300_0000_0000, 0,
              1, 0, 0, 1, 8'h20, 64'h0);
        cyc_b("b dword acc", TN, 1, 3, 24'h8, 64'h4455_0000_0000_0000, 0,
              1, 0, 0, 1, 8'hC0, 64'h0);
        cyc_b("b oversize acc", TN, 1, 4, 24'h10, 64'h0102_0304_0506_0708, 0,
              1, 0, 0, 1, 8'hFF, 64'h0);
        cyc_b("b err1", TI, 0, 3, 24'h0, 64'h0, 0, 0, 1, 0, 0, 8'h00, 64'h0);
        cyc_b("b err2", TI, 0, 3, 24'h0, 64'h0, 0, 1, 1, 0, 0, 8'h00, 64'h0);
        cyc_b("b err done", TI, 0, 3, 24'h0, 64'h0, 0, 1, 0, 0, 0, 8'h00, 64'h0);
        cyc_b("b lat2 acc", TN, 0, 3, 24'h0, 64'h0, 0, 1, 0, 1, 0, 8'h00, 64'h0);
        cyc_b("b lat2 wait", TI, 0, 3, 24'h0, 64'h0, 0, 0, 0, 0, 0, 8'h00, 64'h0);
        cyc_b("b lat2 data", TI, 0, 3, 24'h0, 64'h0, 0, 1, 0, 0, 0, 8'h00,
              64'h4455_3300_0000_0000);
        cyc_b("b lat2 idle", TI, 0, 3, 24'h0, 64'h0, 0, 1, 0, 0, 0, 8'h00, 64'h0);
        cyc_b("b hold acc", TN, 0, 3, 24'h8, 64'h0, 5, 1, 0, 1, 0, 8'h00, 64'h0);
        for (int k = 0; k < 5; k++) begin
            cyc_b($sformatf("b hold wait%0d", k), TI, 0, 3, 24'h0, 64'h0, 0,
                  0, 0, 0, 0, 8'h00, 64'h0);
        end
        cyc_b("b hold data", TI, 0, 3, 24'h0, 64'h0, 0, 1, 0, 0, 0, 8'h00,
              64'h0102_0304_0506_0708);
        cyc_b("b hold idle", TI, 0, 3, 24'h0, 64'h0, 0, 1, 0, 0, 0, 8'h00, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
